box_scanner: RTL
================

# box_scanner

Input front-end for the 3x3 fire/gold board. It scans the 3x3 key/pad matrix and debounces every key per frame, then presents the stable `box[8:0]` occupancy vector that the game controller checks for collisions and catches. It also debounces the start button into a single-cycle `start_pulse`, so one button press advances the controller FSM exactly one step (INIT→PLAY or FINISH→INIT).

## Interface
Parameters:
- `SCAN_DIV`, default 50000: clk cycles each row is driven (dwell). Must be ≥ 4.
- `DEB_SCANS`, default 4: consecutive full frames a new value must persist before it is accepted. Must be ≥ 1.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `row_n`  out  3  row drive, one-hot active-low
- `col_n`  in  3  column sense, active-low (pulled up), asynchronous to clk
- `start_btn`  in  1  raw start push-button, active-high, asynchronous
- `box`  out  9  debounced key state; `box[3*r+c]` is row r, column c
- `box_press`  out  9  one-cycle pulse per key on its debounced 0→1 transition
- `start_pulse`  out  1  one-cycle pulse on debounced start 0→1
- `frame_done`  out  1  one-cycle pulse at the end of each full scan frame

## Operation
- `col_n` and `start_btn` each pass through a 2-flop synchronizer before any use.
- Row FSM states and row drive:
  - ROW0: `row_n`=3'b110
  - ROW1: `row_n`=3'b101
  - ROW2: `row_n`=3'b011
- Row FSM sequence is ROW0→ROW1→ROW2→ROW0. The dwell counter runs 0..SCAN_DIV-1 and the state advances on the edge where the counter equals SCAN_DIV-1.
- Sampling happens on that same edge. Synchronized `~col_n[c]` is captured into `raw[3*r+c]` for the current row r. Sampling at end of dwell absorbs row settling plus synchronizer latency.
- Frame end is the ROW2 sampling edge. On that edge the debounce step uses {row-2 sample, raw[5:0]}, so the frame's fresh row-2 data is included.
- Per-key debounce, one counter per key of width clog2(DEB_SCANS+1), evaluated only at frame end:
  - If `raw[k]` == `box[k]`: counter ← 0.
  - Else if counter+1 == DEB_SCANS: `box[k]` ← `raw[k]`, counter ← 0, and `box_press[k]`=1 if the new value is 1.
  - Else: counter ← counter+1.
- Start debounce uses the same rule at the same frame tick, on the synchronized `start_btn`. `start_pulse`=1 on the accepted 0→1 transition only. A held button gives no repeat and a release gives no pulse.
- Any number of keys may be active simultaneously. The matrix has per-key diodes, so the block contains no anti-ghost logic.
- Reset values: `row_n`=3'b110, FSM=ROW0, dwell counter=0, `raw`=0, `box`=0, `box_press`=0, `start_pulse`=0, `frame_done`=0, all debounce counters=0, synchronizers=0.
- Reset asserted mid-frame clears everything immediately, including pending counts. Scanning restarts at ROW0, count 0, on the first edge after release.

## Timing
- Row period is SCAN_DIV cycles; frame period is 3·SCAN_DIV cycles.
- `frame_done`, `box` updates, `box_press` and `start_pulse` all assert in the cycle following the frame-end edge, and last exactly 1 cycle.
- `row_n` changes to 3'b110 on the same frame-end edge.
- First `frame_done` after reset release: high in cycle 3·SCAN_DIV (cycles counted from 1 at the first edge after release).
- Press latency, from a stable column change to `box` update: between DEB_SCANS−1 and DEB_SCANS full frames plus ≤1 frame, plus 2 sync cycles. Release latency is the same.
- A key that alternates on consecutive frames never reaches DEB_SCANS and never changes `box`.

## Test plan
Run all scenarios with SCAN_DIV=4, DEB_SCANS=2.
- **Reset / idle:** hold `rst`, then release with `col_n`=3'b111.
  - `row_n` cycles 110/101/011 with 4 cycles each.
  - `frame_done` is high 1 cycle every 12 cycles.
  - `box`=0 and no pulses.
- **Single press:** drive `col_n[2]` low only while `row_n`=3'b101 (key 5) for 3 frames.
  - `box`=9'b000100000 after the 2nd frame end.
  - `box_press`=9'b000100000 for exactly 1 cycle, coincident with `frame_done`.
- **Bounce rejection:** key 5 active for 1 frame, inactive the next, repeated 4 times.
  - `box` stays 0 and `box_press` never asserts.
- **Release and simultaneous keys:**
  - Keys 0 and 8 become active in the same frame → `box`=9'b100000001 and `box_press`=9'b100000001 in one cycle.
  - Release both for 2 frames → `box`=0 with no pulse.
- **Start button:**
  - `start_btn` high for 5 frames → exactly one `start_pulse`, in the same cycle as the 2nd `frame_done`.
  - Release, then press again → a second single pulse.
- **Reset mid-operation:** assert `rst` during ROW1 while key 5 is stable and `box[5]`=1.
  - Immediately `box`=0 and `row_n`=3'b110.
  - After release, `box[5]` returns only after 2 frames.

Source files
------------

// File: rtl/box_scanner_if.sv
// Signal bundle between the box_scanner front-end and the 3x3 key matrix / game logic.
// master is the scanner side; slave is the matrix/controller side.
interface box_scanner_if;
   logic [2:0] row_n;
   logic [2:0] col_n;
   logic       start_btn;
   logic [8:0] box;
   logic [8:0] box_press;
   logic       start_pulse;
   logic       frame_done;

   modport master (
      output row_n, box, box_press, start_pulse, frame_done,
      input  col_n, start_btn
   );

   modport slave (
      input  row_n, box, box_press, start_pulse, frame_done,
      output col_n, start_btn
   );
endinterface

// File: rtl/box_scanner.sv
// 3x3 key matrix scanner with per-frame debounce of every key and the start button.
// Debounced state, press pulses and frame_done all update one cycle after the ROW2 sampling edge.
module box_scanner #(
   parameter int unsigned SCAN_DIV  = 50000,
   parameter int unsigned DEB_SCANS = 4
) (
   input  logic          clk,
   input  logic          rst,
   box_scanner_if.master bus
);

   localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned DebW = $clog2(DEB_SCANS + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(SCAN_DIV - 1);
   localparam logic [DebW-1:0] DebLast = DebW'(DEB_SCANS - 1);

   typedef enum logic [1:0] {StRow0, StRow1, StRow2} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      col_meta_q, col_sync_q;
   logic            start_meta_q, start_sync_q;
   logic [8:0]      raw_q, raw_d;
   // Bit 9 of the debounce vectors is the start button; bits 8:0 are the keys.
   logic [9:0]      stable_q, stable_d;
   logic [9:0]      press_q, press_d;
   logic [DebW-1:0] deb_cnt_q [10];
   logic [DebW-1:0] deb_cnt_d [10];
   logic            frame_done_q;
   logic [2:0]      key_act;
   logic            dwell_end;
   logic            frame_end;
   logic [9:0]      deb_in;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_meta_q   <= '0;
         col_sync_q   <= '0;
         start_meta_q <= 1'b0;
         start_sync_q <= 1'b0;
      end else begin
         col_meta_q   <= bus.col_n;
         col_sync_q   <= col_meta_q;
         start_meta_q <= bus.start_btn;
         start_sync_q <= start_meta_q;
      end
   end

   assign key_act   = ~col_sync_q;
   assign dwell_end = (cnt_q == CntLast);
   assign frame_end = dwell_end && (state_q == StRow2);
   // Fresh row-2 data joins the frame's debounce step directly, bypassing raw_q.
   assign deb_in    = {start_sync_q, key_act, raw_q[5:0]};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + CntW'(1);
      raw_d     = raw_q;
      bus.row_n = 3'b110;
      case (state_q)
         StRow0:  bus.row_n = 3'b110;
         StRow1:  bus.row_n = 3'b101;
         StRow2:  bus.row_n = 3'b011;
         default: bus.row_n = 3'b110;
      endcase
      if (dwell_end) begin
         cnt_d = '0;
         case (state_q)
            StRow0: begin
               state_d    = StRow1;
               raw_d[2:0] = key_act;
            end
            StRow1: begin
               state_d    = StRow2;
               raw_d[5:3] = key_act;
            end
            StRow2: begin
               state_d    = StRow0;
               raw_d[8:6] = key_act;
            end
            default: state_d = StRow0;
         endcase
      end
   end

   always_comb begin
      stable_d = stable_q;
      press_d  = '0;
      for (int k = 0; k < 10; k++) begin
         deb_cnt_d[k] = deb_cnt_q[k];
         if (frame_end) begin
            if (deb_in[k] == stable_q[k]) begin
               deb_cnt_d[k] = '0;
            end else if (deb_cnt_q[k] == DebLast) begin
               stable_d[k]  = deb_in[k];
               deb_cnt_d[k] = '0;
               press_d[k]   = deb_in[k];
            end else begin
               deb_cnt_d[k] = deb_cnt_q[k] + DebW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StRow0;
         cnt_q        <= '0;
         raw_q        <= '0;
         stable_q     <= '0;
         press_q      <= '0;
         frame_done_q <= 1'b0;
         for (int k = 0; k < 10; k++) deb_cnt_q[k] <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         raw_q        <= raw_d;
         stable_q     <= stable_d;
         press_q      <= press_d;
         frame_done_q <= frame_end;
         for (int k = 0; k < 10; k++) deb_cnt_q[k] <= deb_cnt_d[k];
      end
   end

   assign bus.box         = stable_q[8:0];
   assign bus.box_press   = press_q[8:0];
   assign bus.start_pulse = press_q[9];
   assign bus.frame_done  = frame_done_q;

endmodule
